// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter (mem_arbiter).
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Read-tag delay line: carries {valid, port} alongside the RAM read latency.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic    clock,
  input  logic    clear,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port data RAM (port 0 = CPU, port 1 = aux).
// MEM_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_W       = MEM_ADDR_W,
  parameter int unsigned DATA_W       = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address_ram,
  output logic [DATA_W-1:0] data_ram,
  output logic              wren_ram,
  input  logic [DATA_W-1:0] q_ram
);

  localparam int unsigned TAG_DEPTH = READ_LATENCY + 1;

  logic     w_acc;
  mem_req_t w_sel;
  rd_tag_t  w_tag_in;
  rd_tag_t  w_tag_out;

`ifdef MEM_ARB_RR_EN
  logic r_last;
`endif

  // Zero-latency grant; at most one port wins per cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_RR_EN
      if (req0 && req1) begin
        gnt0 = (r_last == PORT_AUX);
        gnt1 = (r_last == PORT_CPU);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`else
      gnt0 = req0;
      gnt1 = req1 && !req0;
`endif
    end
  end

  always_comb begin
    w_acc    = gnt0 | gnt1;
    w_tag_in = '0;
    if (gnt1) begin
      w_sel = '{we: we1, addr: MEM_ADDR_W'(addr1), wdata: MEM_DATA_W'(wdata1)};
    end else begin
      w_sel = '{we: we0, addr: MEM_ADDR_W'(addr0), wdata: MEM_DATA_W'(wdata0)};
    end
    w_tag_in.valid = w_acc & ~w_sel.we;
    w_tag_in.port  = gnt1 ? PORT_AUX : PORT_CPU;
  end

  mem_arb_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clock (clock),
    .clear (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // RAM-side command registers and per-port read return
  always_ff @(posedge clock) begin
    if (reset) begin
      address_ram <= '0;
      data_ram    <= '0;
      wren_ram    <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      wren_ram <= w_acc & w_sel.we;
      if (w_acc) begin
        address_ram <= ADDR_W'(w_sel.addr);
        data_ram    <= DATA_W'(w_sel.wdata);
      end
      rvalid0 <= w_tag_out.valid && (w_tag_out.port == PORT_CPU);
      rvalid1 <= w_tag_out.valid && (w_tag_out.port == PORT_AUX);
      if (w_tag_out.valid && (w_tag_out.port == PORT_CPU)) rdata0 <= q_ram;
      if (w_tag_out.valid && (w_tag_out.port == PORT_AUX)) rdata1 <= q_ram;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset value makes port 0 win the first conflict
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= PORT_AUX;
    end else if (w_acc) begin
      r_last <= gnt1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and an in-order read scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned RL = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, wren_ram;
  logic [DW-1:0] rdata0, rdata1, data_ram, q_ram;
  logic [AW-1:0] address_ram;

  mem_arbiter #(.READ_LATENCY(RL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .address_ram(address_ram), .data_ram(data_ram), .wren_ram(wren_ram),
    .q_ram(q_ram)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          m_e;
  logic [DW-1:0] m_got;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_rv     = 0;
  int unsigned   cyc      = 0;
  logic          eg0, eg1;
  logic          m_last = PORT_AUX;
  logic [DW-1:0] ram    [256];
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] qpipe  [RL];

  // Registered-address, registered-output RAM with RL cycles of read latency
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (wren_ram) ram[address_ram[7:0]] <= data_ram;
    qpipe[0] <= ram[address_ram[7:0]];
    for (int i = 1; i < int'(RL); i++) qpipe[i] <= qpipe[i-1];
  end
  assign q_ram = qpipe[RL-1];

  // Response monitor: every rvalid must match the oldest outstanding read
  always @(negedge clock) begin
    if (rvalid0 || rvalid1) begin
      n_rv++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b at cycle %0d, no read outstanding",
                 rvalid0, rvalid1, cyc);
      end else begin
        m_e   = sb.pop_front();
        m_got = rvalid1 ? rdata1 : rdata0;
        if ((rvalid0 && rvalid1) || rvalid1 !== m_e.port || m_got !== m_e.data || cyc !== m_e.cyc) begin
          n_fail++;
          $display("FAIL read_return: got rv0=%b rv1=%b data=%h cyc=%0d, want port=%0d data=%h cyc=%0d",
                   rvalid0, rvalid1, m_got, cyc, m_e.port, m_e.data, m_e.cyc);
        end
      end
    end
  end

  // Drive one cycle of requests, predict grants, update the model on accepts
  task automatic apply(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [AW-1:0] a;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_RR_EN
      if (r0 && r1) begin
        eg0 = (m_last == PORT_AUX);
        eg1 = !eg0;
      end else begin
        eg0 = r0;
        eg1 = r1;
      end
`else
      eg0 = r0;
      eg1 = r1 && !r0;
`endif
    end
    if (eg0 || eg1) begin
`ifdef MEM_ARB_RR_EN
      m_last = eg1;
`endif
      a = eg1 ? a1 : a0;
      if (eg1 ? w1 : w0) shadow[a[7:0]] = eg1 ? d1 : d0;
      else sb.push_back('{port: eg1, data: shadow[a[7:0]], cyc: cyc + RL + 2});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    idle(int'(RL) + 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    sb.delete();
    m_last = PORT_AUX;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b0, 16'h0002, '0);
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: gnt0=%b gnt1=%b, want 0 0", gnt0, gnt1);
    end
    @(negedge clock);
    n_checks++;
    if ({address_ram, data_ram, wren_ram, rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h data=%h wren=%b rv=%b%b rd0=%h rd1=%h, want all 0",
               address_ram, data_ram, wren_ram, rvalid0, rvalid1, rdata0, rdata1);
    end
    reset = 1'b0;
    sb.delete();
    m_last = PORT_AUX;
    idle(1);
  endtask

  task automatic test_write_read();
    apply(1'b1, 1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_gnt: gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
    end
    @(negedge clock);
    n_checks++;
    if (wren_ram !== 1'b1 || address_ram !== 16'h0005 || data_ram !== 16'h1234) begin
      n_fail++;
      $display("FAIL wr_ram: wren=%b addr=%h data=%h, want 1 0005 1234", wren_ram, address_ram, data_ram);
    end
    apply(1'b1, 1'b0, 16'h0005, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_gnt: gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
    end
    @(negedge clock);
    n_checks++;
    if (wren_ram !== 1'b0 || address_ram !== 16'h0005) begin
      n_fail++;
      $display("FAIL rd_ram: wren=%b addr=%h, want 0 0005", wren_ram, address_ram);
    end
    drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL wr_rd_drain: %0d reads outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_conflict();
    do_reset();
    apply(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0020, 16'hA0A0);
    @(negedge clock);
    apply(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0021, 16'hB1B1);
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 16'h0020, '0, 1'b1, 1'b0, 16'h0021, '0);
      n_checks++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        n_fail++;
        $display("FAIL conflict_gnt[%0d]: gnt0=%b gnt1=%b, want %b %b", i, gnt0, gnt1, eg0, eg1);
      end
      @(negedge clock);
    end
    apply(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0021, '0);
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_release: gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
    end
    @(negedge clock);
    drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL conflict_drain: %0d reads outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_cross_port();
    apply(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    n_checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      n_fail++;
      $display("FAIL xport_wr_gnt: gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
    end
    @(negedge clock);
    apply(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL xport_rd_gnt: gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
    end
    @(negedge clock);
    drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL xport_drain: %0d reads outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset_inflight();
    int rv_before;
    apply(1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    apply(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0021, '0);
    @(negedge clock);
    apply(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_checks++;
    if (sb.size() != 3) begin
      n_fail++;
      $display("FAIL inflight_accepts: %0d reads outstanding, want 3", sb.size());
    end
    rv_before = n_rv;
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 16'h0020, '0, 1'b1, 1'b0, 16'h0021, '0);
      n_checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_reset_gnt[%0d]: gnt0=%b gnt1=%b, want 0 0", i, gnt0, gnt1);
      end
      @(negedge clock);
      n_checks++;
      if ({address_ram, data_ram, wren_ram, rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
        n_fail++;
        $display("FAIL inflight_reset_out[%0d]: addr=%h data=%h wren=%b rv=%b%b rd0=%h rd1=%h, want all 0",
                 i, address_ram, data_ram, wren_ram, rvalid0, rvalid1, rdata0, rdata1);
      end
    end
    reset = 1'b0;
    m_last = PORT_AUX;
    idle(8);
    n_checks++;
    if (n_rv != rv_before) begin
      n_fail++;
      $display("FAIL inflight_dropped: %0d rvalid pulses after reset, want 0", n_rv - rv_before);
    end
  endtask

  task automatic test_idle_hold();
    apply(1'b1, 1'b1, 16'h0033, 16'h5A5A, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_checks++;
    if (wren_ram !== 1'b1 || address_ram !== 16'h0033) begin
      n_fail++;
      $display("FAIL hold_wr: wren=%b addr=%h, want 1 0033", wren_ram, address_ram);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_checks++;
      if (wren_ram !== 1'b0 || address_ram !== 16'h0033 || data_ram !== 16'h5A5A) begin
        n_fail++;
        $display("FAIL hold_idle[%0d]: wren=%b addr=%h data=%h, want 0 0033 5a5a",
                 i, wren_ram, address_ram, data_ram);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    for (int i = 0; i < int'(RL); i++) qpipe[i] = '0;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(negedge clock);
    test_reset();
    test_write_read();
    test_conflict();
    test_cross_port();
    test_reset_inflight();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by 200000, want finish");
    $fatal(1, "timeout");
  end

endmodule
